sweep_profile_sequencer: RTL

Plays a programmable list of sweep segments into `sweep_controller`, driving its `base_freq`, `sweep_mode`, `sweep_range` and `sweep_speed` inputs. Each segment runs for a set number of milliseconds. The sequencer either stops after the last segment or loops back to the first. It sits between the front-panel/UART configuration logic and `sweep_controller`, and is the sole owner of the sweep configuration inputs.

---
 rtl/sweep_profile_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sweep_profile_sequencer.sv
// Segment-table player that owns the sweep_controller configuration inputs.
// Each table entry is applied for its duration in ms, then the next one is loaded or playback ends or wraps.
module sweep_profile_sequencer #(
  parameter  int NUM_SEG       = 4,
  parameter  int CYCLES_PER_MS = 100000,
  localparam int AW            = $clog2(NUM_SEG),
  localparam int PW            = $clog2(CYCLES_PER_MS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [19:0]   cfg_base_freq,
  input  logic [1:0]    cfg_mode,
  input  logic [16:0]   cfg_range,
  input  logic [12:0]   cfg_speed,
  input  logic [15:0]   cfg_dur_ms,
  input  logic [AW:0]   num_segs,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  output logic [19:0]   base_freq,
  output logic [1:0]    sweep_mode,
  output logic [16:0]   sweep_range,
  output logic [12:0]   sweep_speed,
  output logic          busy,
  output logic [AW-1:0] seg_idx,
  output logic          seg_start,
  output logic          done
);

  localparam logic [19:0] DEF_BASE = 20'd100000;
  localparam logic [AW:0] NSEG_W   = (AW+1)'(NUM_SEG);
  localparam logic [PW-1:0] PRESC_TC = PW'(CYCLES_PER_MS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_t;

  logic [19:0] tbl_base_q  [NUM_SEG];
  logic [1:0]  tbl_mode_q  [NUM_SEG];
  logic [16:0] tbl_range_q [NUM_SEG];
  logic [12:0] tbl_speed_q [NUM_SEG];
  logic [15:0] tbl_dur_q   [NUM_SEG];

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   ms_q;
  logic [AW:0]   n_act_q;
  logic [AW-1:0] seg_idx_q;
  logic [19:0]   base_q;
  logic [1:0]    mode_q;
  logic [16:0]   range_q;
  logic [12:0]   speed_q;
  logic          busy_q;
  logic          seg_start_q;
  logic          done_q;

  logic addr_ok;
  logic presc_tc;
  logic seg_end;
  logic more_segs;

  assign addr_ok   = 32'(cfg_addr) < 32'(NUM_SEG);
  assign presc_tc  = (presc_q == PRESC_TC);
  // The ms counter never sits at 0 in RUN, so "reaches 0 on this tick" means it is 1 now.
  assign seg_end   = presc_tc && (ms_q <= 16'd1);
  assign more_segs = ({1'b0, seg_idx_q} + (AW+1)'(1)) < n_act_q;

  // NOTE: the table is flop-based with a reset because every slot has a defined power-up profile;
  // a plain RAM without reset would play garbage if started before being programmed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        tbl_base_q[i]  <= DEF_BASE;
        tbl_mode_q[i]  <= 2'b00;
        tbl_range_q[i] <= '0;
        tbl_speed_q[i] <= '0;
        tbl_dur_q[i]   <= 16'd1;
      end
    end else if (cfg_we && addr_ok) begin
      tbl_base_q[cfg_addr]  <= cfg_base_freq;
      tbl_mode_q[cfg_addr]  <= cfg_mode;
      tbl_range_q[cfg_addr] <= cfg_range;
      tbl_speed_q[cfg_addr] <= cfg_speed;
      tbl_dur_q[cfg_addr]   <= cfg_dur_ms;
    end
  end

  // NOTE: all state and outputs live in one clocked block using non-blocking assignments only,
  // so every output is a flop and no read here sees a value updated earlier in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      ms_q        <= '0;
      n_act_q     <= '0;
      seg_idx_q   <= '0;
      base_q      <= DEF_BASE;
      mode_q      <= 2'b00;
      range_q     <= '0;
      speed_q     <= '0;
      busy_q      <= 1'b0;
      seg_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      seg_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (stop) begin
        state_q <= S_IDLE;
        mode_q  <= 2'b00;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && (num_segs != '0)) begin
              state_q   <= S_LOAD;
              busy_q    <= 1'b1;
              seg_idx_q <= '0;
              n_act_q   <= (num_segs > NSEG_W) ? NSEG_W : num_segs;
            end
          end
          S_LOAD: begin
            base_q      <= tbl_base_q[seg_idx_q];
            mode_q      <= tbl_mode_q[seg_idx_q];
            range_q     <= tbl_range_q[seg_idx_q];
            speed_q     <= tbl_speed_q[seg_idx_q];
            ms_q        <= (tbl_dur_q[seg_idx_q] == 16'd0) ? 16'd1 : tbl_dur_q[seg_idx_q];
            presc_q     <= '0;
            seg_start_q <= 1'b1;
            state_q     <= S_RUN;
          end
          S_RUN: begin
            if (presc_tc) begin
              presc_q <= '0;
              if (ms_q != 16'd0) ms_q <= ms_q - 16'd1;
            end else begin
              presc_q <= presc_q + PW'(1);
            end
            if (seg_end) begin
              if (more_segs) begin
                seg_idx_q <= seg_idx_q + AW'(1);
                state_q   <= S_LOAD;
              end else if (loop_en) begin
                seg_idx_q <= '0;
                state_q   <= S_LOAD;
              end else begin
                state_q <= S_FINISH;
                busy_q  <= 1'b0;
              end
            end
          end
          S_FINISH: begin
            mode_q  <= 2'b00;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign base_freq   = base_q;
  assign sweep_mode  = mode_q;
  assign sweep_range = range_q;
  assign sweep_speed = speed_q;
  assign busy        = busy_q;
  assign seg_idx     = seg_idx_q;
  assign seg_start   = seg_start_q;
  assign done        = done_q;

endmodule
